mse_acc_n: RTL and testbench



---
 rtl/mse_acc_n_if.sv | 29 ++
 rtl/mse_acc_n.sv | 126 ++++++++++++
 tb/tb_mse_acc_n.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/mse_acc_n_if.sv
// Handshake bundle for mse_acc_n: input beat stream in, SSD result stream out.
interface mse_acc_n_if #(
  parameter int DATA_WIDTH = 16,
  parameter int LANES      = 4,
  parameter int ACC_WIDTH  = 48,
  parameter int CNT_WIDTH  = 16
);
  logic                          in_valid;
  logic                          in_ready;
  logic [LANES*DATA_WIDTH-1:0]   in_vctr_1;
  logic [LANES*DATA_WIDTH-1:0]   in_vctr_2;
  logic [LANES-1:0]              in_keep;
  logic                          in_last;
  logic                          out_valid;
  logic                          out_ready;
  logic [ACC_WIDTH-1:0]          out_sum;
  logic [CNT_WIDTH-1:0]          out_count;
  logic                          out_overflow;

  modport master (
    output in_valid, in_vctr_1, in_vctr_2, in_keep, in_last, out_ready,
    input  in_ready, out_valid, out_sum, out_count, out_overflow
  );

  modport slave (
    input  in_valid, in_vctr_1, in_vctr_2, in_keep, in_last, out_ready,
    output in_ready, out_valid, out_sum, out_count, out_overflow
  );
endinterface

// File: rtl/mse_acc_n.sv
// Streaming sum-of-squared-differences accumulator over LANES element pairs per beat.
// Define MSE_ACC_SATURATE_EN to clamp the accumulator and report a sticky overflow.
//
// state | meaning
// ACCUM | accepting beats, accumulating into the running sum
// DRAIN | last beat accepted, waiting for it to leave the pipeline
// HOLD  | result presented on out_*, waiting for out_ready
module mse_acc_n #(
  parameter int DATA_WIDTH = 16,
  parameter int LANES      = 4,
  parameter int ACC_WIDTH  = 48,
  parameter int CNT_WIDTH  = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  mse_acc_n_if.slave  bus
);
  localparam int SQ_W  = 2 * DATA_WIDTH;
  localparam int SUM_W = SQ_W + $clog2(LANES);

  typedef enum logic [1:0] {ACCUM, DRAIN, HOLD} state_t;

  state_t               state, state_nx;
  logic                 in_rdy_q;
  logic                 beat_ok;
  logic                 res_hs;
  logic [SQ_W-1:0]      sq_d  [LANES];
  logic [SQ_W-1:0]      s1_sq [LANES];
  logic                 s1_valid, s1_last;
  logic [SUM_W-1:0]     tree_sum, s2_sum;
  logic                 s2_valid, s2_last;
  logic                 s3_done;
  logic [ACC_WIDTH-1:0] acc_q, acc_nx;
  logic [CNT_WIDTH-1:0] cnt_q;

  assign beat_ok       = bus.in_valid && in_rdy_q;
  assign res_hs        = (state == HOLD) && bus.out_ready;
  assign bus.in_ready  = in_rdy_q;
  assign bus.out_valid = (state == HOLD);
  assign bus.out_sum   = acc_q;
  assign bus.out_count = cnt_q;

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    logic [DATA_WIDTH-1:0] a, b, d;
    assign a        = bus.in_vctr_1[g*DATA_WIDTH +: DATA_WIDTH];
    assign b        = bus.in_vctr_2[g*DATA_WIDTH +: DATA_WIDTH];
    assign d        = (a >= b) ? (a - b) : (b - a);
    assign sq_d[g]  = bus.in_keep[g] ? (SQ_W'(d) * SQ_W'(d)) : '0;
  end

  always_comb begin
    tree_sum = '0;
    for (int i = 0; i < LANES; i++) begin
      tree_sum = tree_sum + SUM_W'(s1_sq[i]);
    end
  end

  // Only the valid/last flags need reset; data registers follow their valids.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_last  <= 1'b0;
      s2_valid <= 1'b0;
      s2_last  <= 1'b0;
      s3_done  <= 1'b0;
    end else begin
      s1_valid <= beat_ok;
      s1_last  <= beat_ok && bus.in_last;
      s2_valid <= s1_valid;
      s2_last  <= s1_valid && s1_last;
      s3_done  <= s2_valid && s2_last;
    end
  end

  always_ff @(posedge clk) begin
    if (beat_ok)  s1_sq  <= sq_d;
    if (s1_valid) s2_sum <= tree_sum;
  end

`ifdef MSE_ACC_SATURATE_EN
  logic [ACC_WIDTH:0] acc_sum;
  logic               ovf_q;
  assign acc_sum = {1'b0, acc_q} + (ACC_WIDTH+1)'(s2_sum);
  assign acc_nx  = acc_sum[ACC_WIDTH] ? '1 : acc_sum[ACC_WIDTH-1:0];

  always_ff @(posedge clk) begin
    if (!rst_n || res_hs)                   ovf_q <= 1'b0;
    else if (s2_valid && acc_sum[ACC_WIDTH]) ovf_q <= 1'b1;
  end

  assign bus.out_overflow = ovf_q && (state == HOLD);
`else
  assign acc_nx           = acc_q + ACC_WIDTH'(s2_sum);
  assign bus.out_overflow = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n || res_hs) acc_q <= '0;
    else if (s2_valid)    acc_q <= acc_nx;
  end

  always_ff @(posedge clk) begin
    if (!rst_n || res_hs)            cnt_q <= '0;
    else if (beat_ok && cnt_q != '1) cnt_q <= cnt_q + CNT_WIDTH'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= ACCUM;
      in_rdy_q <= 1'b0;
    end else begin
      state    <= state_nx;
      in_rdy_q <= (state_nx == ACCUM);
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      ACCUM:   if (beat_ok && bus.in_last) state_nx = DRAIN;
      DRAIN:   if (s3_done)                state_nx = HOLD;
      HOLD:    if (bus.out_ready)          state_nx = ACCUM;
      default:                             state_nx = ACCUM;
    endcase
  end
endmodule

// File: tb/tb_mse_acc_n.sv
// Directed scoreboard bench for mse_acc_n (16-bit data, 4 lanes, 33-bit accumulator).
module tb_mse_acc_n;
  localparam int DW = 16;
  localparam int LN = 4;
  localparam int AW = 33;
  localparam int CW = 16;
  localparam logic [63:0] MAXV = (64'd1 << AW) - 64'd1;

  typedef struct {
    logic [63:0] sum;
    logic [63:0] cnt;
    logic        ovf;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mse_acc_n_if #(.DATA_WIDTH(DW), .LANES(LN), .ACC_WIDTH(AW), .CNT_WIDTH(CW)) bus ();

  mse_acc_n #(.DATA_WIDTH(DW), .LANES(LN), .ACC_WIDTH(AW), .CNT_WIDTH(CW)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int          total = 0;
  int          bad = 0;
  exp_t        sb[$];
  logic [63:0] m_acc = 64'd0;
  logic [63:0] m_cnt = 64'd0;
  logic        m_ovf = 1'b0;
  int          acc_cyc = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] pack(input logic [15:0] d0, input logic [15:0] d1,
                                       input logic [15:0] d2, input logic [15:0] d3);
    return {d3, d2, d1, d0};
  endfunction

  task automatic send_beat(input logic [63:0] v1, input logic [63:0] v2,
                           input logic [3:0] keep, input logic last);
    int          n;
    logic [15:0] a, b;
    logic [63:0] dd, bs;
    n = 0;
    bus.in_vctr_1 = v1;
    bus.in_vctr_2 = v2;
    bus.in_keep   = keep;
    bus.in_last   = last;
    bus.in_valid  = 1'b1;
    while (bus.in_ready !== 1'b1 && n < 50) begin
      step();
      n++;
    end
    check("accept_ready", 64'(bus.in_ready), 64'd1);
    step();
    acc_cyc = cyc;
    bus.in_valid = 1'b0;
    bs = 64'd0;
    for (int i = 0; i < 4; i++) begin
      a  = v1[i*16 +: 16];
      b  = v2[i*16 +: 16];
      dd = (a > b) ? 64'(a - b) : 64'(b - a);
      if (keep[i]) bs = bs + dd * dd;
    end
    m_acc = m_acc + bs;
`ifdef MSE_ACC_SATURATE_EN
    if (m_acc > MAXV) begin
      m_acc = MAXV;
      m_ovf = 1'b1;
    end
`else
    m_acc = m_acc & MAXV;
`endif
    if (m_cnt != 64'hFFFF) m_cnt = m_cnt + 64'd1;
    if (last) begin
      sb.push_back('{sum: m_acc, cnt: m_cnt, ovf: m_ovf});
      m_acc = 64'd0;
      m_cnt = 64'd0;
      m_ovf = 1'b0;
    end
  endtask

  task automatic get_result(input int hold);
    exp_t e;
    int   n;
    n = 0;
    e = '{sum: 64'd0, cnt: 64'd0, ovf: 1'b0};
    while (bus.out_valid !== 1'b1 && n < 20) begin
      check("ready_low_drain", 64'(bus.in_ready), 64'd0);
      step();
      n++;
    end
    check("out_valid_seen", 64'(bus.out_valid), 64'd1);
    check("latency", 64'(cyc - acc_cyc), 64'd3);
    check("sb_size", 64'(sb.size()), 64'd1);
    if (sb.size() > 0) e = sb.pop_front();
    check("out_sum", 64'(bus.out_sum), e.sum);
    check("out_count", 64'(bus.out_count), e.cnt);
    check("out_overflow", 64'(bus.out_overflow), 64'(e.ovf));
    repeat (hold) begin
      bus.in_valid = 1'b1;
      step();
      check("hold_valid", 64'(bus.out_valid), 64'd1);
      check("hold_sum", 64'(bus.out_sum), e.sum);
      check("hold_count", 64'(bus.out_count), e.cnt);
      check("hold_ready", 64'(bus.in_ready), 64'd0);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    step();
    check("valid_drop", 64'(bus.out_valid), 64'd0);
    check("ready_after_hs", 64'(bus.in_ready), 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic seen;
    bus.in_valid  = 1'b0;
    bus.in_vctr_1 = '0;
    bus.in_vctr_2 = '0;
    bus.in_keep   = '0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b1;
    rst_n = 1'b0;
    repeat (3) step();
    check("rst_in_ready", 64'(bus.in_ready), 64'd0);
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_out_sum", 64'(bus.out_sum), 64'd0);
    check("rst_out_count", 64'(bus.out_count), 64'd0);
    check("rst_out_overflow", 64'(bus.out_overflow), 64'd0);
    rst_n = 1'b1;
    step();
    check("ready_after_rst", 64'(bus.in_ready), 64'd1);

    // single beat: 9+16+0+100
    send_beat(pack(16'd10, 16'd20, 16'd30, 16'd40), pack(16'd13, 16'd16, 16'd30, 16'd50), 4'hF, 1'b1);
    get_result(0);

    // three back-to-back beats, every diff 2
    send_beat(pack(16'd5, 16'd5, 16'd5, 16'd5), pack(16'd7, 16'd7, 16'd7, 16'd7), 4'hF, 1'b0);
    send_beat(pack(16'd9, 16'd0, 16'd2, 16'd4), pack(16'd7, 16'd2, 16'd0, 16'd2), 4'hF, 1'b0);
    send_beat(pack(16'd2, 16'd2, 16'd2, 16'd2), pack(16'd0, 16'd0, 16'd0, 16'd0), 4'hF, 1'b1);
    get_result(0);

    // partial last beat, with an idle in_last that must be ignored
    send_beat(pack(16'd1, 16'd1, 16'd1, 16'd1), pack(16'd0, 16'd0, 16'd0, 16'd0), 4'hF, 1'b0);
    bus.in_last = 1'b1;
    step();
    step();
    bus.in_last = 1'b0;
    send_beat(pack(16'd1, 16'd2, 16'd100, 16'd100), pack(16'd0, 16'd0, 16'd0, 16'd0), 4'b0011, 1'b1);
    get_result(0);

    // all-zero keep beat, then a long HOLD with in_valid asserted
    bus.out_ready = 1'b0;
    send_beat(pack(16'd5, 16'd5, 16'd5, 16'd5), pack(16'd0, 16'd0, 16'd0, 16'd0), 4'h0, 1'b0);
    send_beat(pack(16'd2, 16'd0, 16'd0, 16'd0), pack(16'd0, 16'd0, 16'd0, 16'd0), 4'hF, 1'b1);
    get_result(10);
    send_beat(pack(16'd10, 16'd20, 16'd30, 16'd40), pack(16'd13, 16'd16, 16'd30, 16'd50), 4'hF, 1'b1);
    get_result(0);

    // reset pulse while draining discards the vector
    send_beat(pack(16'd3, 16'd3, 16'd3, 16'd3), pack(16'd0, 16'd0, 16'd0, 16'd0), 4'hF, 1'b1);
    rst_n = 1'b0;
    step();
    check("ready_in_rst", 64'(bus.in_ready), 64'd0);
    rst_n = 1'b1;
    if (sb.size() > 0) void'(sb.pop_back());
    seen = 1'b0;
    repeat (6) begin
      step();
      seen = seen | bus.out_valid;
    end
    check("no_valid_after_rst", 64'(seen), 64'd0);
    send_beat(pack(16'd3, 16'd0, 16'd0, 16'd0), pack(16'd0, 16'd0, 16'd0, 16'd0), 4'hF, 1'b1);
    get_result(0);

    // overflow: full-scale diffs on every lane
    repeat (2) send_beat(pack(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF), pack(16'd0, 16'd0, 16'd0, 16'd0), 4'hF, 1'b0);
    send_beat(pack(16'd0, 16'd0, 16'd0, 16'd0), pack(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF), 4'hF, 1'b1);
    get_result(0);
    send_beat(pack(16'd10, 16'd20, 16'd30, 16'd40), pack(16'd13, 16'd16, 16'd30, 16'd50), 4'hF, 1'b1);
    get_result(0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
